// File: rtl/matrix_stream_feeder.sv
// Operand feeder for the systolic array: buffers up to K {A column, B row} beats,
// then streams them under valid/ready with last marking, and can replay the held tile.
module matrix_stream_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int DEPTH_BITS = $clog2(K + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]     in_a,
  input  logic [N-1:0][DATA_WIDTH-1:0]     in_b,
  input  logic                             in_last,
  input  logic                             replay,
  output logic                             out_valid,
  input  logic                             array_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]     out_a,
  output logic [N-1:0][DATA_WIDTH-1:0]     out_b,
  output logic                             out_last,
  output logic                             tile_done,
  output logic [DEPTH_BITS-1:0]            depth,
  output logic                             busy
);

  localparam int IDX_BITS = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t                      state, state_nxt;
  logic [DEPTH_BITS-1:0]       wr_cnt, wr_cnt_nxt;
  logic [DEPTH_BITS-1:0]       rd_ptr, rd_ptr_nxt;
  logic [DEPTH_BITS-1:0]       depth_nxt;
  logic                        tile_done_nxt;
  logic                        wr_en;
  logic [IDX_BITS-1:0]         wr_idx;
  logic                        accept;
  logic                        last_beat;

  logic [N-1:0][DATA_WIDTH-1:0] buf_a [K];
  logic [N-1:0][DATA_WIDTH-1:0] buf_b [K];

  // Gating with reset keeps in_ready low for the whole time reset is held.
  always_comb begin
    in_ready  = reset && (((state == IDLE) && !replay) || (state == LOAD));
    accept    = in_valid && in_ready;
    last_beat = (rd_ptr == depth - 1'b1);
    out_valid = (state == STREAM);
    out_last  = out_valid && last_beat;
    out_a     = out_valid ? buf_a[rd_ptr[IDX_BITS-1:0]] : '0;
    out_b     = out_valid ? buf_b[rd_ptr[IDX_BITS-1:0]] : '0;
    busy      = (state != IDLE);
  end

  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    rd_ptr_nxt    = rd_ptr;
    depth_nxt     = depth;
    tile_done_nxt = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = '0;
    case (state)
      IDLE: begin
        if (replay && (depth != '0)) begin
          state_nxt  = STREAM;
          rd_ptr_nxt = '0;
        end else if (accept) begin
          wr_en      = 1'b1;
          wr_cnt_nxt = DEPTH_BITS'(1);
          depth_nxt  = DEPTH_BITS'(1);
          rd_ptr_nxt = '0;
          state_nxt  = (in_last || (K == 1)) ? STREAM : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_idx     = wr_cnt[IDX_BITS-1:0];
          wr_cnt_nxt = wr_cnt + 1'b1;
          depth_nxt  = depth + 1'b1;
          if (in_last || (wr_cnt == DEPTH_BITS'(K - 1))) begin
            state_nxt  = STREAM;
            rd_ptr_nxt = '0;
          end
        end
      end
      STREAM: begin
        if (array_ready) begin
          rd_ptr_nxt = rd_ptr + 1'b1;
          if (last_beat) begin
            state_nxt     = IDLE;
            tile_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      depth     <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      rd_ptr    <= rd_ptr_nxt;
      depth     <= depth_nxt;
      tile_done <= tile_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_a[wr_idx] <= in_a;
      buf_b[wr_idx] <= in_b;
    end
  end

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Bench for matrix_stream_feeder: table of hand vectors, directed corner sequences,
// then random traffic against a queue-based tile model.
module tb_matrix_stream_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DB = $clog2(K + 1);

  typedef logic [N-1:0][DW-1:0] lane_t;

  logic          clk;
  logic          reset;
  logic          in_valid, in_ready, in_last, replay;
  lane_t         in_a, in_b, out_a, out_b;
  logic          out_valid, array_ready, out_last, tile_done, busy;
  logic [DB-1:0] depth;

  matrix_stream_feeder #(.DATA_WIDTH(DW), .N(N), .K(K), .DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .replay(replay), .out_valid(out_valid), .array_ready(array_ready),
    .out_a(out_a), .out_b(out_b), .out_last(out_last),
    .tile_done(tile_done), .depth(depth), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the retained tile is a queue of beats; streaming walks an index through it.
  lane_t qa[$];
  lane_t qb[$];
  bit    m_loading, m_streaming, m_done;
  int    m_pos;

  typedef struct {
    logic  iv, il, rp, ar;
    lane_t a, b;
    logic  e_rdy, e_val, e_last, e_done, e_busy;
    lane_t e_a, e_b;
    int    e_depth;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lane_t pat(input logic [DW-1:0] base);
    lane_t v;
    for (int i = 0; i < N; i++) v[i] = base + DW'(i);
    return v;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_loading   = 1'b0;
    m_streaming = 1'b0;
    m_done      = 1'b0;
    m_pos       = 0;
  endtask

  task automatic check_model();
    bit    e_rdy;
    lane_t ea, eb;
    e_rdy = !m_streaming && (m_loading || !replay);
    ea    = m_streaming ? qa[m_pos] : '0;
    eb    = m_streaming ? qb[m_pos] : '0;
    check("in_ready", 64'(in_ready), 64'(e_rdy));
    check("out_valid", 64'(out_valid), 64'(m_streaming));
    check("out_last", 64'(out_last), 64'(m_streaming && (m_pos == qa.size() - 1)));
    check("out_a", 64'(out_a), 64'(ea));
    check("out_b", 64'(out_b), 64'(eb));
    check("tile_done", 64'(tile_done), 64'(m_done));
    check("depth", 64'(depth), 64'(qa.size()));
    check("busy", 64'(busy), 64'(m_loading || m_streaming));
  endtask

  task automatic model_step();
    bit accepted;
    m_done   = 1'b0;
    accepted = in_valid && !m_streaming && (m_loading || !replay);
    if (m_streaming) begin
      if (array_ready) begin
        if (m_pos == qa.size() - 1) begin
          m_streaming = 1'b0;
          m_done      = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end else if (!m_loading && replay && qa.size() != 0) begin
      m_streaming = 1'b1;
      m_pos       = 0;
    end else if (accepted) begin
      if (!m_loading) begin
        qa.delete();
        qb.delete();
      end
      qa.push_back(in_a);
      qb.push_back(in_b);
      m_loading = 1'b1;
      if (in_last || qa.size() == K) begin
        m_loading   = 1'b0;
        m_streaming = 1'b1;
        m_pos       = 0;
      end
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    advance();
  endtask

  task automatic drive(input logic iv, input logic il, input logic rp, input logic ar,
                       input lane_t a, input lane_t b);
    in_valid    = iv;
    in_last     = il;
    replay      = rp;
    array_ready = ar;
    in_a        = a;
    in_b        = b;
  endtask

  task automatic idle(input int n, input logic ar);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, ar, '0, '0);
      cycle();
    end
  endtask

  task automatic load_tile(input int n, input bit last_on_final, input logic [DW-1:0] seed);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, last_on_final && (i == n - 1), 1'b0, 1'b0,
            pat(seed + DW'(16 * i)), pat(seed + DW'(16 * i) + 8'h08));
      cycle();
    end
  endtask

  int n_xfer;
  bit last_pos_ok;

  initial begin
    model_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_depth", 64'(depth), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full 4-beat tile, last on beat 4, array always ready.
    for (int k = 0; k < 4; k++) begin
      tbl[k] = '{iv:1'b1, il:(k == 3), rp:1'b0, ar:1'b0,
                 a:pat(8'h10 * DW'(k + 1)), b:pat(8'h80 + 8'h10 * DW'(k + 1)),
                 e_rdy:1'b1, e_val:1'b0, e_last:1'b0, e_done:1'b0, e_busy:(k != 0),
                 e_a:'0, e_b:'0, e_depth:k};
      tbl[k + 4] = '{iv:1'b0, il:1'b0, rp:1'b0, ar:1'b1, a:'0, b:'0,
                     e_rdy:1'b0, e_val:1'b1, e_last:(k == 3), e_done:1'b0, e_busy:1'b1,
                     e_a:pat(8'h10 * DW'(k + 1)), e_b:pat(8'h80 + 8'h10 * DW'(k + 1)), e_depth:4};
    end
    tbl[8] = '{iv:1'b0, il:1'b0, rp:1'b0, ar:1'b1, a:'0, b:'0, e_rdy:1'b1, e_val:1'b0,
               e_last:1'b0, e_done:1'b1, e_busy:1'b0, e_a:'0, e_b:'0, e_depth:4};
    tbl[9] = '{iv:1'b0, il:1'b0, rp:1'b0, ar:1'b1, a:'0, b:'0, e_rdy:1'b1, e_val:1'b0,
               e_last:1'b0, e_done:1'b0, e_busy:1'b0, e_a:'0, e_b:'0, e_depth:4};

    foreach (tbl[r]) begin
      drive(tbl[r].iv, tbl[r].il, tbl[r].rp, tbl[r].ar, tbl[r].a, tbl[r].b);
      @(negedge clk);
      check("tbl_in_ready", 64'(in_ready), 64'(tbl[r].e_rdy));
      check("tbl_out_valid", 64'(out_valid), 64'(tbl[r].e_val));
      check("tbl_out_last", 64'(out_last), 64'(tbl[r].e_last));
      check("tbl_out_a", 64'(out_a), 64'(tbl[r].e_a));
      check("tbl_out_b", 64'(out_b), 64'(tbl[r].e_b));
      check("tbl_tile_done", 64'(tile_done), 64'(tbl[r].e_done));
      check("tbl_busy", 64'(busy), 64'(tbl[r].e_busy));
      check("tbl_depth", 64'(depth), 64'(tbl[r].e_depth));
      check_model();
      advance();
    end

    // Replay of the retained tile with the array always ready.
    drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    cycle();
    idle(6, 1'b1);

    // Replay with a stalling array: exactly 4 transfers, last on the 4th only.
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    n_xfer      = 0;
    last_pos_ok = 1'b1;
    begin
      bit rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      foreach (rdy_pat[i]) begin
        drive(1'b0, 1'b0, 1'b0, rdy_pat[i], '0, '0);
        @(negedge clk);
        if (out_valid && array_ready) begin
          n_xfer++;
          if (out_last != (n_xfer == 4)) last_pos_ok = 1'b0;
        end
        check_model();
        advance();
      end
    end
    check("stall_xfer_count", 64'(n_xfer), 64'd4);
    check("stall_last_position", 64'(last_pos_ok), 64'd1);
    idle(2, 1'b0);

    // Replay and in_valid in the same IDLE cycle: replay wins, beat refused.
    drive(1'b1, 1'b1, 1'b1, 1'b1, pat(8'hE0), pat(8'hF0));
    cycle();
    idle(6, 1'b1);

    // Short tile of 2 beats.
    load_tile(2, 1'b1, 8'h21);
    idle(4, 1'b1);
    check("short_depth", 64'(depth), 64'd2);

    // Overflow: 4 beats without last; a 5th beat is held off until IDLE.
    load_tile(4, 1'b0, 8'h33);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, pat(8'h55), pat(8'h66));
      cycle();
    end
    idle(3, 1'b1);

    // Asynchronous reset after two beats have streamed.
    load_tile(4, 1'b1, 8'h40);
    idle(2, 1'b1);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_last", 64'(out_last), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_depth", 64'(depth), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Replay with nothing retained does nothing.
    drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    cycle();
    idle(2, 1'b1);

    // Fresh tile after reset.
    load_tile(3, 1'b1, 8'h70);
    idle(5, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) != 0, lane_t'($urandom), lane_t'($urandom));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
